pla_misg_event_capture: RTL
===========================

Name: pla_misg_event_capture

Overview:
Registered capture stage directly downstream of the misg PLA. Samples the PLA's 23-bit output vector (z00..z22 concatenated, z00 = bit 0) and filters glitches with a stability counter. Emits one record per accepted change of the filtered vector: the new vector plus a mask of the bits that changed. Records are buffered in a small first-word-fall-through FIFO with a valid/ready output.

Parameters:
STABLE_CYCLES, 2, extra consecutive matching samples required before a value is accepted (1..15)
DEPTH, 4, FIFO entries; power of two, 2..16
INIT_VECTOR, 23'h000000, accepted-vector value after reset
TS_W, 16, timestamp width (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
z_in  input  23  PLA output vector, z00 = bit 0
sample_en  input  1  sampling/filter enable
out_valid  output  1  head record available
out_ready  input  1  consumer accepts head record
out_data  output  23  head record: accepted vector
out_mask  output  23  head record: changed bits (new XOR previous accepted)
out_stamp  output  TS_W  head record timestamp (PLA_MISG_CAP_TIMESTAMP_EN only)
fifo_level  output  5  number of stored records, 0..DEPTH
overflow  output  1  sticky: a record was dropped because the FIFO was full
clear_overflow  input  1  clears overflow

Behaviour:
- Reset (asynchronous, any time, including mid-operation) sets:
  - s0, cand, cnt to 0; accepted = INIT_VECTOR
  - FIFO empty; out_valid = 0; out_data = out_mask = 0; fifo_level = 0; overflow = 0; stamp counter = 0
- Sample stage: when sample_en = 1, s0 <= z_in each edge. When sample_en = 0, s0, cand and cnt hold. The FIFO and pops are unaffected by sample_en.
- Filter, evaluated on enabled edges:
  - s0 != cand: cand <= s0, cnt <= 0.
  - s0 == cand and cnt < STABLE_CYCLES: cnt <= cnt + 1.
  - s0 == cand, cnt == STABLE_CYCLES, cand != accepted: accept. accepted <= cand; push {cand, cand ^ accepted}; cnt holds.
  - s0 == cand, cnt == STABLE_CYCLES, cand == accepted: no action.
- Latency: z_in held at value V across the enabled edges k .. k+STABLE_CYCLES+1 (V first captured into s0 at edge k) is pushed at edge k+STABLE_CYCLES+2. out_valid rises after that edge if the FIFO was empty. With the default: V applied before edge 1, out_valid = 1 after edge 5.
- Handshake: pop occurs on an edge where out_valid & out_ready. out_data and out_mask always show the head record and are 0 when the FIFO is empty. The head record stays stable while out_valid = 1 and out_ready = 0.
- Push when full with no pop: record dropped, overflow <= 1. accepted still updates, so the next mask is relative to the dropped vector.
- Push and pop on the same edge when full: both succeed; level unchanged; no overflow.
- Push and pop on the same edge when level = 1: the new record becomes head; out_valid stays 1.
- Pointer wrap-around uses log2(DEPTH) bits. Full and empty are tracked from fifo_level.
- clear_overflow and a new drop on the same edge: overflow = 1 (set wins).

Optional Feature:
PLA_MISG_CAP_TIMESTAMP_EN
- Defined:
  - A free-running TS_W-bit counter increments every edge and wraps from all-ones to 0.
  - Each record stores the counter value at its push edge; out_stamp shows the head's stamp and is 0 when empty.
- Undefined: the out_stamp port, counter and storage are absent; all other behaviour is identical.

Test Plan:
- Reset, z_in = 0 held 10 cycles -> out_valid = 0, fifo_level = 0. Then z_in = 23'h000001 before edge 1 -> after edge 5: out_valid = 1, out_data = 000001, out_mask = 000001.
- Glitch: accepted = 000001; z_in = 000003 for 2 edges, then 000001 -> no record, fifo_level stays 0.
- Overflow: out_ready = 0; apply 5 distinct stable vectors 000002, 000004, 000008, 000010, 000020 -> fifo_level = 4, overflow = 1. Popping returns the first four in order; masks 000003, 000006, 00000C, 000018.
- Simultaneous push/pop: FIFO full, out_ready = 1 on the edge a new record is accepted -> fifo_level stays 4, overflow stays 0, new record is last out. clear_overflow with no new drop -> overflow = 0.
- Reset mid-operation: fifo_level = 3, rst pulsed between edges -> out_valid, out_data, fifo_level, overflow are 0 immediately. Re-applying INIT_VECTOR produces no record.
- sample_en = 0 while z_in changes to 000040 -> no record. Re-enable with z_in held -> record appears STABLE_CYCLES+2 enabled edges later. With PLA_MISG_CAP_TIMESTAMP_EN, stamps strictly increase and wrap correctly at 16'hFFFF -> 0.

Source files
------------

// File: rtl/pla_misg_event_capture.sv
// Glitch-filtered capture of the misg PLA output vector into a small FWFT record FIFO.
// Define PLA_MISG_CAP_TIMESTAMP_EN to add a free-running timestamp to every record (out_stamp).
module pla_misg_event_capture #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned DEPTH         = 4,
    parameter logic [22:0] INIT_VECTOR   = 23'h000000,
    parameter int unsigned TS_W          = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [22:0]     z_in,
    input  logic            sample_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [22:0]     out_data,
    output logic [22:0]     out_mask,
`ifdef PLA_MISG_CAP_TIMESTAMP_EN
    output logic [TS_W-1:0] out_stamp,
`endif
    output logic [4:0]      fifo_level,
    output logic            overflow,
    input  logic            clear_overflow
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  STABLE  = 4'(STABLE_CYCLES);
    localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

    logic [22:0]   s0_reg;
    logic [22:0]   cand_reg;
    logic [22:0]   accepted_reg;
    logic [3:0]    cnt_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [4:0]    level_reg;
    logic          overflow_reg;

    logic [22:0]   data_mem [DEPTH];
    logic [22:0]   mask_mem [DEPTH];

    logic          push_req;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    // A candidate that has survived STABLE_CYCLES extra matching samples and differs from the last accepted value.
    always_comb begin
        push_req = sample_en && (s0_reg == cand_reg) && (cnt_reg == STABLE) && (cand_reg != accepted_reg);
        full     = (level_reg == DEPTH_L);
        pop      = out_valid && out_ready;
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_reg       <= '0;
            cand_reg     <= '0;
            cnt_reg      <= '0;
            accepted_reg <= INIT_VECTOR;
        end else if (sample_en) begin
            s0_reg <= z_in;
            if (s0_reg != cand_reg) begin
                cand_reg <= s0_reg;
                cnt_reg  <= '0;
            end else if (cnt_reg < STABLE) begin
                cnt_reg <= cnt_reg + 4'd1;
            end else if (cand_reg != accepted_reg) begin
                // Accepted even when the record is dropped, so the next mask is relative to it.
                accepted_reg <= cand_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + 5'd1;
                2'b01:   level_reg <= level_reg - 5'd1;
                default: level_reg <= level_reg;
            endcase
            if (drop)
                overflow_reg <= 1'b1;
            else if (clear_overflow)
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr_reg] <= cand_reg;
            mask_mem[wr_ptr_reg] <= cand_reg ^ accepted_reg;
        end
    end

    always_comb begin
        out_valid  = (level_reg != 5'd0);
        out_data   = out_valid ? data_mem[rd_ptr_reg] : '0;
        out_mask   = out_valid ? mask_mem[rd_ptr_reg] : '0;
        fifo_level = level_reg;
        overflow   = overflow_reg;
    end

`ifdef PLA_MISG_CAP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;
    logic [TS_W-1:0] stamp_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ts_reg <= '0;
        else
            ts_reg <= ts_reg + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            stamp_mem[wr_ptr_reg] <= ts_reg;
    end

    always_comb begin
        out_stamp = out_valid ? stamp_mem[rd_ptr_reg] : '0;
    end
`endif

endmodule
